// File: rtl/ser_stream_pkg.sv
// ============================================================================
// Module : ser_stream_pkg
// Brief  : Shared types, engine state encoding and length check for ser_stream_tx.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ser_stream_pkg;

    localparam int SER_WIDTH   = 16;
    localparam int SER_MOD_W   = $clog2(SER_WIDTH + 1);
    localparam int SER_MIN_LEN = 3;

    typedef struct packed {
        logic [SER_WIDTH-1:0] data;
        logic [SER_MOD_W-1:0] len;
        logic                 lsb_first;
    } ser_word_t;

    typedef enum logic [0:0] {
        ENG_IDLE  = 1'b0,
        ENG_SHIFT = 1'b1
    } eng_state_t;

    function automatic logic len_legal(input int len, input int min_len, input int max_len);
        return (len >= min_len) && (len <= max_len);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ser_hold_buf.sv
// ============================================================================
// Module : ser_hold_buf
// Brief  : One-entry holding register with valid/ready on both sides.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ser_hold_buf
    import ser_stream_pkg::*;
#(
    parameter type WORD_T = ser_word_t
) (
    input  logic  clk,
    input  logic  rst,
    input  WORD_T in_word,
    input  logic  in_val,
    output logic  in_ready,
    output WORD_T out_word,
    output logic  out_val,
    input  logic  out_ready
);

    logic  full;
    WORD_T word;

    // Ready depends only on occupancy so the upstream handshake stays registered.
    assign in_ready = !full;
    assign out_val  = full;
    assign out_word = word;

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            word <= '0;
        end else if (in_val && in_ready) begin
            full <= 1'b1;
            word <= in_word;
        end else if (out_ready && full) begin
            full <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ser_stream_tx.sv
// ============================================================================
// Module : ser_stream_tx
// Brief  : Programmable-length word serializer with holding buffer and handshakes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ser_stream_tx
    import ser_stream_pkg::*;
#(
    parameter int WIDTH   = SER_WIDTH,
    parameter int MOD_W   = $clog2(WIDTH + 1),
    parameter int MIN_LEN = SER_MIN_LEN
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [MOD_W-1:0] data_mod_i,
    input  logic             data_lsb_first_i,
    input  logic             data_val_i,
    output logic             data_ready_o,
    output logic             ser_data_o,
    output logic             ser_data_val_o,
    output logic             ser_last_o,
    input  logic             ser_ready_i,
    output logic             busy_o,
    output logic             drop_o
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [MOD_W-1:0] len;
        logic             lsb_first;
    } word_t;

    eng_state_t       state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next, load_rev;
    logic [MOD_W-1:0] cnt, cnt_next, last_idx, last_idx_next;
    word_t            in_word, hold_word, load_word;
    logic             hold_full, hold_ready, hold_push;
    logic             accept, legal, xfer, last_xfer, eng_free, direct, load;

    assign in_word   = '{data: data_i, len: data_mod_i, lsb_first: data_lsb_first_i};
    assign accept    = data_val_i & data_ready_o;
    assign legal     = len_legal(32'(data_mod_i), MIN_LEN, WIDTH);

    assign ser_data_val_o = (state == ENG_SHIFT);
    assign ser_data_o     = ser_data_val_o & shreg[WIDTH-1];
    assign ser_last_o     = ser_data_val_o & (cnt == last_idx);
    assign data_ready_o   = hold_ready;
    assign busy_o         = ser_data_val_o | hold_full;

    assign xfer      = ser_data_val_o & ser_ready_i;
    assign last_xfer = xfer & ser_last_o;
    assign eng_free  = (state == ENG_IDLE) | last_xfer;
    // A new word bypasses the buffer only when nothing older is waiting there.
    assign direct    = accept & legal & eng_free & !hold_full;
    assign hold_push = accept & legal & !direct;
    assign load      = direct | (eng_free & hold_full);
    assign load_word = hold_full ? hold_word : in_word;

    ser_hold_buf #(
        .WORD_T   (word_t)
    ) u_hold_buf (
        .clk      (clk_i),
        .rst      (srst_i),
        .in_word  (in_word),
        .in_val   (hold_push),
        .in_ready (hold_ready),
        .out_word (hold_word),
        .out_val  (hold_full),
        .out_ready(eng_free)
    );

    // LSB-first words are mirrored on load so the engine always shifts out the MSB.
    always_comb begin
        load_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            load_rev[i] = load_word.data[WIDTH-1-i];
        end
    end

    always_comb begin
        state_next    = state;
        shreg_next    = shreg;
        cnt_next      = cnt;
        last_idx_next = last_idx;
        if (load) begin
            state_next    = ENG_SHIFT;
            shreg_next    = load_word.lsb_first ? load_rev : load_word.data;
            cnt_next      = '0;
            last_idx_next = load_word.len - 1'b1;
        end else if (last_xfer) begin
            state_next = ENG_IDLE;
            shreg_next = '0;
            cnt_next   = '0;
        end else if (xfer) begin
            shreg_next = {shreg[WIDTH-2:0], 1'b0};
            cnt_next   = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state    <= ENG_IDLE;
            shreg    <= '0;
            cnt      <= '0;
            last_idx <= '0;
            drop_o   <= 1'b0;
        end else begin
            state    <= state_next;
            shreg    <= shreg_next;
            cnt      <= cnt_next;
            last_idx <= last_idx_next;
            drop_o   <= accept & !legal;
        end
    end

endmodule

`default_nettype wire
